identity_sub_sequencer: RTL and testbench

//  Sequential controller around the I - A step of the pseudoinverse datapath.
//  - Captures an M x N fixed-point matrix on start and walks it element by element.
//  - Streams each (I - A) element out over a valid/ready handshake, with row/col tags.
//  - Builds the full result matrix in an output register and pulses done when finished.
//  - Lets a downstream multiplier or accumulator consume results one element per cycle.

---
 rtl/identity_sub_sequencer_pkg.sv | 25 ++
 rtl/identity_sub_sequencer_elem.sv | 29 ++
 rtl/identity_sub_sequencer.sv | 136 +++++++++++++
 tb/tb_identity_sub_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/identity_sub_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// identity_sub_sequencer_pkg
// Shared definitions for the I - A sequencer and its element datapath.
//   FRAC_DEFAULT : default number of fractional bits of the fixed-point format
//   ONE          : fixed-point 1.0 in the default format (1 << FRAC_DEFAULT)
//   seq_state_t  : controller state encoding (IDLE, RUN, DONE)
//   idx_width()  : width of a row/column index, clog2(n) but never below 1
// ----------------------------------------------------------------------------
package identity_sub_sequencer_pkg;

    localparam int          FRAC_DEFAULT = 15;
    localparam logic [31:0] ONE          = 32'd1 << FRAC_DEFAULT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // A dimension of 1 still needs a one-bit index port.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/identity_sub_sequencer_elem.sv
// ----------------------------------------------------------------------------
// identity_elem
// Combinational single element of I - A, shared with the parallel datapath.
//   a_ij     in   nBits  element of A, two's complement fixed point
//   is_diag  in   1      element lies on the identity diagonal
//   out_data out  nBits  (is_diag ? ONE : 0) - a_ij, modulo 2^nBits
// ----------------------------------------------------------------------------
module identity_elem
    import identity_sub_sequencer_pkg::*;
#(
    parameter int nBits = 32,
    parameter int FRAC  = 15
) (
    input  logic [nBits-1:0] a_ij,
    input  logic             is_diag,
    output logic [nBits-1:0] out_data
);

    // The package constant covers the default format; other formats build
    // their own 1.0 from FRAC.
    localparam logic [nBits-1:0] ONE_VAL = (FRAC == FRAC_DEFAULT) ? nBits'(ONE)
                                                                  : (nBits'(1) << FRAC);

    // Plain nBits subtraction: overflow wraps, there is no saturation.
    always_comb begin
        out_data = (is_diag ? ONE_VAL : '0) - a_ij;
    end

endmodule

// File: rtl/identity_sub_sequencer.sv
// ----------------------------------------------------------------------------
// identity_sub_sequencer
// Captures an M x N matrix A on start, streams every element of I - A in
// row-major order over a valid/ready handshake, collects the result matrix
// in b and pulses done once the last element has been accepted.
//   clk        in   1           rising-edge clock
//   rst_n      in   1           asynchronous active-low reset
//   start      in   1           one-cycle request, a sampled on the same edge
//   a          in   M*N*nBits   element (i,j) at bits [(i*N+j)*nBits +: nBits]
//   busy       out  1           run in progress
//   out_valid  out  1           out_data/out_row/out_col are valid
//   out_ready  in   1           consumer accepts when valid && ready
//   out_data   out  nBits       (I - A)(out_row, out_col)
//   out_row    out  clog2(M)    row index of out_data
//   out_col    out  clog2(N)    column index of out_data
//   b          out  M*N*nBits   result matrix, same packing as a
//   done       out  1           one-cycle pulse after the last acceptance
// ----------------------------------------------------------------------------
module identity_sub_sequencer
    import identity_sub_sequencer_pkg::*;
#(
    parameter int M     = 2,
    parameter int N     = 2,
    parameter int nBits = 32,
    parameter int FRAC  = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [M*N*nBits-1:0]        a,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [nBits-1:0]            out_data,
    output logic [idx_width(M)-1:0]     out_row,
    output logic [idx_width(N)-1:0]     out_col,
    output logic [M*N*nBits-1:0]        b,
    output logic                        done
);

    localparam int RW    = idx_width(M);
    localparam int CW    = idx_width(N);
    localparam int DIAGS = (M < N) ? M : N;

    seq_state_t           state_q;
    seq_state_t           state_d;
    logic [RW-1:0]        row_q;
    logic [CW-1:0]        col_q;
    logic [M*N*nBits-1:0] a_q;
    logic [M*N*nBits-1:0] b_q;

    int                   elem_idx;
    logic [nBits-1:0]     a_ij;
    logic                 is_diag;
    logic [nBits-1:0]     elem_val;
    logic                 accept;
    logic                 last_elem;

    // Select the current element of the captured matrix and classify it.
    // The explicit bound on the diagonal keeps non-square shapes honest even
    // though row == col already implies it for in-range counters.
    always_comb begin
        elem_idx  = int'(row_q) * N + int'(col_q);
        a_ij      = a_q[elem_idx*nBits +: nBits];
        is_diag   = (int'(row_q) == int'(col_q)) && (int'(row_q) < DIAGS);
        last_elem = (row_q == RW'(M-1)) && (col_q == CW'(N-1));
        accept    = (state_q == RUN) && out_ready;
    end

    identity_elem #(
        .nBits (nBits),
        .FRAC  (FRAC)
    ) u_elem (
        .a_ij     (a_ij),
        .is_diag  (is_diag),
        .out_data (elem_val)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. start is only honoured in IDLE, so a request during
    // RUN or DONE is dropped rather than queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accept && last_elem) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Matrix capture, result collection and row-major walk. The counters
    // wrap back to (0,0) after the last element, so they are already clear
    // when the controller idles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            row_q <= '0;
            col_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            a_q   <= a;
            row_q <= '0;
            col_q <= '0;
        end else if (accept) begin
            b_q[elem_idx*nBits +: nBits] <= elem_val;
            if (col_q == CW'(N-1)) begin
                col_q <= '0;
                row_q <= (row_q == RW'(M-1)) ? '0 : row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    // Outputs decode straight from the state. out_data is forced to zero
    // outside RUN so the stream bus reads zero at reset and between runs.
    always_comb begin
        busy      = (state_q == RUN);
        out_valid = (state_q == RUN);
        done      = (state_q == DONE);
        out_data  = (state_q == RUN) ? elem_val : '0;
        out_row   = row_q;
        out_col   = col_q;
        b         = b_q;
    end

endmodule

// File: tb/tb_identity_sub_sequencer.sv
// ----------------------------------------------------------------------------
// tb_identity_sub_sequencer
// Directed bench for identity_sub_sequencer: a 2x2 instance for the main
// stream, stall, restart, reset and wrap cases, and a 2x3 instance for the
// non-square diagonal case. Expected values are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_identity_sub_sequencer;

    logic         clk;
    logic         rst_n;

    logic         start22;
    logic [127:0] a22;
    logic         ready22;
    logic         busy22;
    logic         valid22;
    logic [31:0]  data22;
    logic [0:0]   row22;
    logic [0:0]   col22;
    logic [127:0] b22;
    logic         done22;

    logic         start23;
    logic [191:0] a23;
    logic         ready23;
    logic         busy23;
    logic         valid23;
    logic [31:0]  data23;
    logic [0:0]   row23;
    logic [1:0]   col23;
    logic [191:0] b23;
    logic         done23;

    int vectors;
    int miscompares;

    identity_sub_sequencer #(.M(2), .N(2), .nBits(32), .FRAC(15)) u_dut22 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start22),
        .a         (a22),
        .busy      (busy22),
        .out_valid (valid22),
        .out_ready (ready22),
        .out_data  (data22),
        .out_row   (row22),
        .out_col   (col22),
        .b         (b22),
        .done      (done22)
    );

    identity_sub_sequencer #(.M(2), .N(3), .nBits(32), .FRAC(15)) u_dut23 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start23),
        .a         (a23),
        .busy      (busy23),
        .out_valid (valid23),
        .out_ready (ready23),
        .out_data  (data23),
        .out_row   (row23),
        .out_col   (col23),
        .b         (b23),
        .done      (done23)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs into the selected instance, let the rising
    // edge sample them, and return 1 ns later so outputs are read off-edge.
    task automatic applyStimulus(input bit to23, input logic st, input logic [191:0] av,
                                 input logic rdy);
        if (to23) begin
            start23 = st;
            a23     = av;
            ready23 = rdy;
        end else begin
            start22 = st;
            a22     = av[127:0];
            ready22 = rdy;
        end
        @(posedge clk);
        #1;
    endtask

    // One comparison: counts the vector and reports any miscompare.
    task automatic checkOutput(input string tag, input logic [191:0] obs,
                               input logic [191:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Directed sequence.
    initial begin
        logic [191:0] mat1;
        logic [191:0] mat3;
        logic [191:0] mat5;
        logic [191:0] mat6;
        logic [127:0] res1;
        logic [127:0] res6;
        logic [191:0] res5;
        logic [31:0]  exp1 [4];
        logic [31:0]  exp5 [6];
        logic [31:0]  exp6 [4];
        logic         pat  [4];
        int           idx;
        int           guard;

        vectors     = 0;
        miscompares = 0;
        mat1 = {64'd0, 32'h0002_0000, 32'h0001_8000, 32'h0001_0000, 32'h0000_8000};
        mat3 = {64'd0, 32'h0004_0000, 32'h0004_0000, 32'h0004_0000, 32'h0004_0000};
        mat5 = {6{32'h0000_8000}};
        mat6 = {64'd0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h8000_8000};
        exp1 = '{32'h0000_0000, 32'hFFFF_0000, 32'hFFFE_8000, 32'hFFFE_8000};
        res1 = {32'hFFFE_8000, 32'hFFFE_8000, 32'hFFFF_0000, 32'h0000_0000};
        exp5 = '{32'h0000_0000, 32'hFFFF_8000, 32'hFFFF_8000,
                 32'hFFFF_8000, 32'h0000_0000, 32'hFFFF_8000};
        res5 = {32'hFFFF_8000, 32'h0000_0000, 32'hFFFF_8000,
                32'hFFFF_8000, 32'hFFFF_8000, 32'h0000_0000};
        exp6 = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_8000};
        res6 = {32'h0000_8000, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000};
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst_n   = 1'b0;
        start22 = 1'b0;
        a22     = '0;
        ready22 = 1'b0;
        start23 = 1'b0;
        a23     = '0;
        ready23 = 1'b0;

        // Reset values.
        #12;
        checkOutput("rst_busy",  192'(busy22),  192'(1'b0));
        checkOutput("rst_valid", 192'(valid22), 192'(1'b0));
        checkOutput("rst_done",  192'(done22),  192'(1'b0));
        checkOutput("rst_data",  192'(data22),  192'(0));
        checkOutput("rst_row",   192'(row22),   192'(0));
        checkOutput("rst_col",   192'(col22),   192'(0));
        checkOutput("rst_b",     192'(b22),     192'(0));
        checkOutput("rst_b23",   b23,           192'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: full throughput, done four cycles after the first valid.
        $display("[TB] test 1: ready held high");
        applyStimulus(0, 1'b1, mat1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t1_valid", 192'(valid22), 192'(1'b1));
            checkOutput("t1_busy",  192'(busy22),  192'(1'b1));
            checkOutput("t1_done",  192'(done22),  192'(1'b0));
            checkOutput("t1_data",  192'(data22),  192'(exp1[i]));
            checkOutput("t1_row",   192'(row22),   192'(i / 2));
            checkOutput("t1_col",   192'(col22),   192'(i % 2));
            applyStimulus(0, 1'b0, mat1, 1'b1);
        end
        checkOutput("t1_done_pulse", 192'(done22),  192'(1'b1));
        checkOutput("t1_busy_off",   192'(busy22),  192'(1'b0));
        checkOutput("t1_valid_off",  192'(valid22), 192'(1'b0));
        checkOutput("t1_b",          192'(b22),     192'(res1));
        applyStimulus(0, 1'b0, mat1, 1'b1);
        checkOutput("t1_done_clear", 192'(done22),  192'(1'b0));

        // Test 2: start in the IDLE cycle right after done, then stall.
        $display("[TB] test 2: ready pattern 1,0,0,1");
        applyStimulus(0, 1'b1, mat1, 1'b1);
        idx   = 0;
        guard = 0;
        while (idx < 4 && guard < 40) begin
            checkOutput("t2_valid", 192'(valid22), 192'(1'b1));
            checkOutput("t2_done",  192'(done22),  192'(1'b0));
            checkOutput("t2_data",  192'(data22),  192'(exp1[idx]));
            checkOutput("t2_row",   192'(row22),   192'(idx / 2));
            checkOutput("t2_col",   192'(col22),   192'(idx % 2));
            applyStimulus(0, 1'b0, mat1, pat[guard % 4]);
            if (pat[guard % 4]) idx++;
            guard++;
        end
        checkOutput("t2_accepts",    192'(idx),    192'(4));
        checkOutput("t2_cycles",     192'(guard),  192'(8));
        checkOutput("t2_done_pulse", 192'(done22), 192'(1'b1));
        checkOutput("t2_b",          192'(b22),    192'(res1));
        applyStimulus(0, 1'b0, mat1, 1'b1);
        checkOutput("t2_done_clear", 192'(done22), 192'(1'b0));

        // Test 3: start pulsed again in RUN with a different matrix.
        $display("[TB] test 3: start while busy");
        applyStimulus(0, 1'b1, mat1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t3_data", 192'(data22), 192'(exp1[i]));
            checkOutput("t3_done", 192'(done22), 192'(1'b0));
            applyStimulus(0, (i == 1), (i == 1) ? mat3 : mat1, 1'b1);
        end
        checkOutput("t3_done_pulse", 192'(done22), 192'(1'b1));
        applyStimulus(0, 1'b0, mat3, 1'b1);
        checkOutput("t3_done_once",  192'(done22),  192'(1'b0));
        checkOutput("t3_no_rerun",   192'(busy22),  192'(1'b0));
        applyStimulus(0, 1'b0, mat3, 1'b1);
        checkOutput("t3_still_idle", 192'(valid22), 192'(1'b0));
        checkOutput("t3_b",          192'(b22),     192'(res1));

        // Test 4: asynchronous reset after two acceptances, then a clean run.
        $display("[TB] test 4: reset mid-run");
        applyStimulus(0, 1'b1, mat6, 1'b1);
        applyStimulus(0, 1'b0, mat6, 1'b1);
        applyStimulus(0, 1'b0, mat6, 1'b1);
        checkOutput("t4_pre_busy", 192'(busy22), 192'(1'b1));
        rst_n = 1'b0;
        #1;
        checkOutput("t4_busy",  192'(busy22),  192'(1'b0));
        checkOutput("t4_valid", 192'(valid22), 192'(1'b0));
        checkOutput("t4_done",  192'(done22),  192'(1'b0));
        checkOutput("t4_b",     192'(b22),     192'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b1, mat1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t4_data", 192'(data22), 192'(exp1[i]));
            checkOutput("t4_row",  192'(row22),  192'(i / 2));
            checkOutput("t4_col",  192'(col22),  192'(i % 2));
            applyStimulus(0, 1'b0, mat1, 1'b1);
        end
        checkOutput("t4_done_pulse", 192'(done22), 192'(1'b1));
        checkOutput("t4_b_clean",    192'(b22),    192'(res1));
        applyStimulus(0, 1'b0, mat1, 1'b1);

        // Test 6: wrap-around of ONE - 0x80008000.
        $display("[TB] test 6: two's complement wrap");
        applyStimulus(0, 1'b1, mat6, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t6_data", 192'(data22), 192'(exp6[i]));
            applyStimulus(0, 1'b0, mat6, 1'b1);
        end
        checkOutput("t6_done_pulse", 192'(done22), 192'(1'b1));
        checkOutput("t6_b",          192'(b22),    192'(res6));
        applyStimulus(0, 1'b0, mat6, 1'b1);

        // Test 5: 2x3 instance, diagonal only at (0,0) and (1,1).
        $display("[TB] test 5: non-square 2x3");
        applyStimulus(1, 1'b1, mat5, 1'b1);
        for (int i = 0; i < 6; i++) begin
            checkOutput("t5_valid", 192'(valid23), 192'(1'b1));
            checkOutput("t5_data",  192'(data23),  192'(exp5[i]));
            checkOutput("t5_row",   192'(row23),   192'(i / 3));
            checkOutput("t5_col",   192'(col23),   192'(i % 3));
            checkOutput("t5_done",  192'(done23),  192'(1'b0));
            applyStimulus(1, 1'b0, mat5, 1'b1);
        end
        checkOutput("t5_done_pulse", 192'(done23), 192'(1'b1));
        checkOutput("t5_busy_off",   192'(busy23), 192'(1'b0));
        checkOutput("t5_b",          b23,          res5);
        applyStimulus(1, 1'b0, mat5, 1'b1);
        checkOutput("t5_done_clear", 192'(done23), 192'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
